// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 hex keypad scanner.
//   - kp_state_e     : press-tracking FSM states
//   - ROWS/COLS/...  : matrix geometry and key code width
//   - onehot16_to_code / popcount_is_one : snapshot decoding helpers
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BLOCKED = 2'd2
  } kp_state_e;

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic logic [CODE_W-1:0] onehot16_to_code(input logic [KEYS-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (v[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  function automatic logic popcount_is_one(input logic [KEYS-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a snapshot only after DEBOUNCE consecutive
// identical full scans.
//   clk, rst    : clock, asynchronous active-high reset
//   scan_done   : one-cycle strobe, scan holds a complete 16-bit scan
//   scan        : assembled matrix scan (bit row*4+col)
//   stable      : last accepted snapshot
//   stable_upd  : one-cycle pulse in the cycle stable has just been written
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_done,
  input  logic [KEYS-1:0] scan,
  output logic [KEYS-1:0] stable,
  output logic            stable_upd
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic [KEYS-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEYS-1:0]  stable_q;
  logic             upd_d, upd_q;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (scan_done) begin
      if (scan == cand_q) begin
        cnt_d = sat_inc(cnt_q);
      end else begin
        cand_d = scan;
        cnt_d  = CNT_W'(1);
      end
    end
    // Re-fires on every scan while saturated; consumers see the same value.
    upd_d = scan_done && (cnt_d == CNT_MAX);
  end

  // stage boundary: accepted snapshot and its update strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      upd_q  <= upd_d;
      if (upd_d) stable_q <= cand_d;
    end
  end

  assign stable     = stable_q;
  assign stable_upd = upd_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 keypad one row at a time, debounces
// whole-matrix snapshots and hands out each new single-key press as a
// hex code through a 1-entry valid/ready buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   rows       : one-hot row drive (registered)
//   cols       : column sense, active-high, already synchronised
//   key_valid  : buffered code available
//   key_code   : row*4 + col of the buffered press
//   key_ready  : consumer pops when key_valid && key_ready
//   key_held   : debounced snapshot is non-zero
//   overflow   : sticky, a press arrived while the buffer was full
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4096,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   rows,
  input  logic [COLS-1:0]   cols,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [ROWS-1:0]   rows_q, rows_d;
  logic [KEYS-1:0]   snap_q, snap_d;
  logic [KEYS-1:0]   scan_word;
  logic              scan_tick, scan_done;

  logic [KEYS-1:0]   stable;
  logic              stable_upd;

  kp_state_e         state_q, state_d;
  logic [CODE_W-1:0] held_code_q, held_code_d;
  logic              press_ev;
  logic [CODE_W-1:0] ev_code;

  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              overflow_q, overflow_d;
  logic              pop;

  // Row scanner: the last divider cycle of each row samples its columns.
  always_comb begin
    scan_tick = (div_q == DIV_LAST);
    scan_done = scan_tick && (row_idx_q == 2'd3);
    div_d     = scan_tick ? '0 : div_q + DIV_W'(1);
    row_idx_d = scan_tick ? row_idx_q + 2'd1 : row_idx_q;
    rows_d    = ROWS'(1) << row_idx_d;
    // The current row's columns are merged in so the row-3 bits are part
    // of the scan handed to the debouncer in the same cycle.
    scan_word = snap_q;
    scan_word[{row_idx_q, 2'b00} +: COLS] = cols;
    snap_d    = scan_tick ? scan_word : snap_q;
  end

  // stage boundary: scanner state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      row_idx_q <= 2'd0;
      rows_q    <= 4'b0001;
      snap_q    <= '0;
    end else begin
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      rows_q    <= rows_d;
      snap_q    <= snap_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .scan_done  (scan_done),
    .scan       (scan_word),
    .stable     (stable),
    .stable_upd (stable_upd)
  );

  // Press tracking: only a clean transition from nothing to one key emits
  // an event; any multi-key or changed-key state must fully release first.
  always_comb begin
    state_d     = state_q;
    held_code_d = held_code_q;
    press_ev    = 1'b0;
    ev_code     = onehot16_to_code(stable);
    if (stable_upd) begin
      unique case (state_q)
        IDLE: begin
          if (popcount_is_one(stable)) begin
            press_ev    = 1'b1;
            held_code_d = ev_code;
            state_d     = PRESSED;
          end else if (stable != '0) begin
            state_d = BLOCKED;
          end
        end
        PRESSED: begin
          if (stable == '0) begin
            state_d = IDLE;
          end else if (stable != (KEYS'(1) << held_code_q)) begin
            state_d = BLOCKED;
          end
        end
        BLOCKED: begin
          if (stable == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output buffer: a same-cycle pop frees the slot for an incoming press.
  always_comb begin
    pop         = key_valid_q && key_ready;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = overflow_q;
    if (pop) key_valid_d = 1'b0;
    if (press_ev) begin
      if (!key_valid_q || pop) begin
        key_valid_d = 1'b1;
        key_code_d  = ev_code;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // stage boundary: FSM state and output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      held_code_q <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_code_q <= held_code_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rows      = rows_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = (stable != '0);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle scans).
// A keypad matrix model drives cols from rows; a behavioural model predicts
// all outputs every cycle, and literal expectations pin key scenarios.
module tb_hex_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overflow;
  logic [15:0] keymat = 16'h0000;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its row line to its column line.
  always_comb begin
    cols = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (rows[r]) cols = cols | keymat[r*4 +: 4];
    end
  end

  hex_keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // Behavioural model: cycle count since reset determines the row; a scan
  // is accepted once the last DB complete scans are identical; a press is
  // emitted when a single key appears after an all-released snapshot.
  int          m_n;
  logic [15:0] m_snap;
  logic [15:0] hist[$];
  logic [15:0] m_stable;
  bit          m_fresh;
  bit          m_upd_pend;
  bit          m_valid;
  logic [3:0]  m_code;
  bit          m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n        = 0;
      m_snap     = 16'h0;
      hist.delete();
      m_stable   = 16'h0;
      m_fresh    = 1'b1;
      m_upd_pend = 1'b0;
      m_valid    = 1'b0;
      m_code     = 4'h0;
      m_ovf      = 1'b0;
    end else begin
      bit pop;
      bit same;
      int row;
      pop = m_valid && key_ready;
      if (m_upd_pend) begin
        m_upd_pend = 1'b0;
        if (m_stable == 16'h0) begin
          m_fresh = 1'b1;
        end else begin
          if (m_fresh && $countones(m_stable) == 1) begin
            if (!m_valid || pop) begin
              m_valid = 1'b1;
              for (int i = 0; i < 16; i++) if (m_stable[i]) m_code = 4'(i);
              pop = 1'b0;
            end else begin
              m_ovf = 1'b1;
            end
          end
          m_fresh = 1'b0;
        end
      end
      if (pop) m_valid = 1'b0;
      if (m_n % SD == SD - 1) begin
        row = (m_n / SD) % 4;
        m_snap[row*4 +: 4] = keymat[row*4 +: 4];
        if (row == 3) begin
          hist.push_back(m_snap);
          if (hist.size() > DB) void'(hist.pop_front());
          same = 1'b1;
          foreach (hist[i]) if (hist[i] != m_snap) same = 1'b0;
          if (hist.size() == DB && same) begin
            m_stable   = m_snap;
            m_upd_pend = 1'b1;
          end
        end
      end
      m_n++;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock, then compare every output against the model.
  task automatic tick();
    @(negedge clk);
    chk("rows", {12'h0, rows}, {12'h0, 4'(4'b0001 << ((m_n / SD) % 4))});
    chk("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
    chk("key_code", {12'h0, key_code}, {12'h0, m_code});
    chk("key_held", {15'h0, key_held}, {15'h0, (m_stable != 16'h0)});
    chk("overflow", {15'h0, overflow}, {15'h0, m_ovf});
  endtask

  task automatic scans(input int k);
    repeat (k * SCAN) tick();
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int c;
    c = 0;
    while (!key_valid && c < maxc) begin
      tick();
      c++;
    end
    chk(nm, {15'h0, key_valid}, 16'h1);
  endtask

  task automatic pop_key(input string nm);
    #1 key_ready = 1'b1;
    tick();
    #1 key_ready = 1'b0;
    chk(nm, {15'h0, key_valid}, 16'h0);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_rows"}, {12'h0, rows}, 16'h0001);
    chk({nm, "_valid"}, {15'h0, key_valid}, 16'h0);
    chk({nm, "_code"}, {12'h0, key_code}, 16'h0);
    chk({nm, "_held"}, {15'h0, key_held}, 16'h0);
    chk({nm, "_ovf"}, {15'h0, overflow}, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    #1 rst = 1'b0;

    // Idle scanning: after 4 cycles row 1 is driven.
    repeat (4) tick();
    chk("rows_row1", {12'h0, rows}, 16'h0002);
    scans(6);
    chk("idle_no_valid", {15'h0, key_valid}, 16'h0);

    // Single press of key 9 (row 2, col 1), no consumer.
    #1 keymat = 16'h0200;
    wait_valid("press9_valid", 5 * SCAN);
    chk("press9_code", {12'h0, key_code}, 16'h0009);
    chk("press9_held", {15'h0, key_held}, 16'h1);
    pop_key("press9_pop");
    scans(3);
    chk("press9_no_repeat", {15'h0, key_valid}, 16'h0);
    #1 keymat = 16'h0000;
    scans(3);

    // Bounce for 5 scans, then hold.
    repeat (5) begin
      #1 keymat = keymat ^ 16'h0200;
      scans(1);
      chk("bounce_quiet", {15'h0, key_valid}, 16'h0);
    end
    wait_valid("bounce_valid", 4 * SCAN);
    chk("bounce_code", {12'h0, key_code}, 16'h0009);
    pop_key("bounce_pop");
    scans(2);
    chk("bounce_single", {15'h0, key_valid}, 16'h0);
    chk("bounce_no_ovf", {15'h0, overflow}, 16'h0);
    #1 keymat = 16'h0000;
    scans(3);

    // Two keys together, then release down to one: no event.
    #1 keymat = 16'h8001;
    scans(4);
    chk("two_keys_quiet", {15'h0, key_valid}, 16'h0);
    chk("two_keys_held", {15'h0, key_held}, 16'h1);
    #1 keymat = 16'h0001;
    scans(4);
    chk("release_to_one_quiet", {15'h0, key_valid}, 16'h0);
    #1 keymat = 16'h0000;
    scans(3);
    chk("all_released", {15'h0, key_held}, 16'h0);
    #1 keymat = 16'h0020;
    wait_valid("press5_valid", 5 * SCAN);
    chk("press5_code", {12'h0, key_code}, 16'h0005);
    pop_key("press5_pop");
    #1 keymat = 16'h0000;
    scans(3);

    // Buffer full: second press is dropped and flagged.
    #1 keymat = 16'h0008;
    wait_valid("press3_valid", 5 * SCAN);
    #1 keymat = 16'h0000;
    scans(3);
    #1 keymat = 16'h0080;
    scans(4);
    chk("ovf_code_kept", {12'h0, key_code}, 16'h0003);
    chk("ovf_valid", {15'h0, key_valid}, 16'h1);
    chk("ovf_set", {15'h0, overflow}, 16'h1);
    pop_key("ovf_pop");
    chk("ovf_sticky", {15'h0, overflow}, 16'h1);
    #1 keymat = 16'h0000;
    scans(3);

    // Reset while a key is buffered and mid-scan, key kept held.
    #1 keymat = 16'h0200;
    wait_valid("pre_reset_valid", 5 * SCAN);
    tick();
    tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    tick();
    tick();
    #1 rst = 1'b0;
    wait_valid("post_reset_valid", 4 * SCAN);
    chk("post_reset_code", {12'h0, key_code}, 16'h0009);
    pop_key("post_reset_pop");
    scans(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
